// File: rtl/icache_pkg.sv
// icache_pkg: shared constants for the instruction cache and its memory-controller
// block-read interface (state encodings, geometry defaults, handshake timing).
package icache_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned BLOCK_W         = 32;
    localparam int unsigned ENTRY_BITS_DEF  = 4;

    // Controller timing for one block read: memory read cycles, controller
    // overhead cycles, and the gap before it re-samples a query after confirming.
    localparam int unsigned MEM_READ_CYCLES = 4;
    localparam int unsigned CTRL_CYCLES     = 2;
    localparam int unsigned CONFIRM_GAP     = 1;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays for the direct-mapped cache.
//   clk_in, rst_in : clock, synchronous active-high reset (clears valid bits only)
//   wr_en          : write a line (valid=1, tag, data) at wr_idx
//   wr_idx/wr_tag/wr_data : write port
//   rd_idx         : combinational read index
//   rd_valid/rd_tag/rd_data : line contents at rd_idx
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned ENTRY_BITS = ENTRY_BITS_DEF,
    parameter int unsigned TAG_W      = ADDR_W - ENTRY_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en,
    input  logic [ENTRY_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [BLOCK_W-1:0]    wr_data,
    input  logic [ENTRY_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_W-1:0]    rd_data
);

    localparam int unsigned LINES = 1 << ENTRY_BITS;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    // Valid bits: only storage that needs a reset value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data payload: no reset, contents are qualified by the valid bit.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   rdy_in          : global ready; low freezes every register
//   clear_in        : abandon pending fetch (flush / mispredict)
//   fetch_en/fetch_addr   : fetch request pulse and byte address
//   fetch_ready/fetch_inst: one-cycle response pulse and instruction word
//   mem_query_en/mem_head_addr : block-read request to the memory controller
//   mem_block_en/mem_block_data: block-read response from the controller
module icache
    import icache_pkg::*;
#(
    parameter int unsigned ENTRY_BITS = ENTRY_BITS_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic [BLOCK_W-1:0] fetch_inst,
    output logic               mem_query_en,
    output logic [ADDR_W-1:0]  mem_head_addr,
    input  logic               mem_block_en,
    input  logic [BLOCK_W-1:0] mem_block_data
);

    localparam int unsigned TAG_W = ADDR_W - ENTRY_BITS - 2;

    state_t state;
    state_t state_next;

    logic               drop;
    logic               drop_next;
    logic               fetch_ready_next;
    logic [BLOCK_W-1:0] fetch_inst_next;
    logic               mem_query_en_next;
    logic [ADDR_W-1:0]  mem_head_addr_next;
    logic               fill_en_c;

    logic [ENTRY_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic [ENTRY_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  hit_c;
    logic                  fetch_go_c;
    logic                  unused_addr_bits;

    // Lookup uses the live fetch address; the fill uses the latched query address.
    assign rd_idx     = fetch_addr[ENTRY_BITS+1:2];
    assign fetch_tag  = fetch_addr[ADDR_W-1:ENTRY_BITS+2];
    assign wr_idx     = mem_head_addr[ENTRY_BITS+1:2];
    assign wr_tag     = mem_head_addr[ADDR_W-1:ENTRY_BITS+2];
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign hit_c      = line_valid && (line_tag == fetch_tag);
    assign fetch_go_c = fetch_en && !clear_in;

    icache_line_store #(
        .ENTRY_BITS (ENTRY_BITS),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .wr_en    (fill_en_c && rdy_in && !rst_in),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (mem_block_data),
        .rd_idx   (rd_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fetch_go_c && !hit_c) begin
                    state_next = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_block_en) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Output / datapath next values. fetch_ready is a pulse, so it defaults to 0;
    // a clear in IDLE therefore also kills any response that is currently showing.
    always_comb begin
        fetch_ready_next   = 1'b0;
        fetch_inst_next    = fetch_inst;
        mem_query_en_next  = mem_query_en;
        mem_head_addr_next = mem_head_addr;
        drop_next          = drop;
        fill_en_c          = 1'b0;
        unique case (state)
            IDLE: begin
                drop_next = 1'b0;
                if (fetch_go_c) begin
                    if (hit_c) begin
                        fetch_ready_next = 1'b1;
                        fetch_inst_next  = line_data;
                    end else begin
                        mem_query_en_next  = 1'b1;
                        mem_head_addr_next = {fetch_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            MISS_WAIT: begin
                if (mem_block_en) begin
                    // Fill always lands; only the response is suppressed by a clear.
                    mem_query_en_next = 1'b0;
                    fill_en_c         = 1'b1;
                    drop_next         = 1'b0;
                    if (!drop && !clear_in) begin
                        fetch_ready_next = 1'b1;
                        fetch_inst_next  = mem_block_data;
                    end
                end else if (clear_in) begin
                    // Controller cannot abort, so keep the query up and drop the result.
                    drop_next = 1'b1;
                end
            end
        endcase
    end

    // Registered outputs and drop flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_ready   <= 1'b0;
            fetch_inst    <= '0;
            mem_query_en  <= 1'b0;
            mem_head_addr <= '0;
            drop          <= 1'b0;
        end else if (rdy_in) begin
            fetch_ready   <= fetch_ready_next;
            fetch_inst    <= fetch_inst_next;
            mem_query_en  <= mem_query_en_next;
            mem_head_addr <= mem_head_addr_next;
            drop          <= drop_next;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache with a behavioural line model and
// a bench-driven memory controller.
module tb_icache;
    import icache_pkg::*;

    localparam int unsigned EB      = 4;
    localparam int unsigned M_LINES = 16;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_query_en;
    logic [31:0] mem_head_addr;
    logic        mem_block_en;
    logic [31:0] mem_block_data;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [M_LINES];
    logic [31:0] m_tag   [M_LINES];
    logic [31:0] m_data  [M_LINES];

    icache #(.ENTRY_BITS(EB)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .fetch_en       (fetch_en),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .fetch_inst     (fetch_inst),
        .mem_query_en   (mem_query_en),
        .mem_head_addr  (mem_head_addr),
        .mem_block_en   (mem_block_en),
        .mem_block_data (mem_block_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backing memory contents as seen through the controller.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return 32'((a >> 2) % M_LINES);
    endfunction

    function automatic logic [31:0] m_tg(input logic [31:0] a);
        return a >> (EB + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
    endfunction

    // One fetch: hit response, or miss + query + controller reply + fill.
    // clear_mode: 0 none, 1 clear the cycle after the query, 2 clear with mem_block_en.
    task automatic do_fetch(input logic [31:0] addr, input int clear_mode, input int wait_cyc);
        bit          hit;
        logic [31:0] d;
        logic [31:0] head;
        int unsigned idx;
        hit  = m_hit(addr);
        idx  = m_idx(addr);
        head = addr & 32'hFFFF_FFFC;
        fetch_en = 1'b1; fetch_addr = addr;
        step();
        fetch_en = 1'b0; fetch_addr = $urandom;
        if (hit) begin
            n_checks++;
            if (fetch_ready !== 1'b1 || fetch_inst !== m_data[idx]) begin
                n_fail++;
                $display("FAIL hit_resp addr=%h: ready=%b inst=%h, expected ready=1 inst=%h", addr, fetch_ready, fetch_inst, m_data[idx]);
            end
            n_checks++;
            if (mem_query_en !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_noquery addr=%h: query=%b, expected 0", addr, mem_query_en);
            end
            step();
        end else begin
            n_checks++;
            if (mem_query_en !== 1'b1 || mem_head_addr !== head || fetch_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_query addr=%h: query=%b head=%h ready=%b, expected 1 %h 0", addr, mem_query_en, mem_head_addr, fetch_ready, head);
            end
            if (clear_mode == 1) begin
                clear_in = 1'b1;
                step();
                clear_in = 1'b0;
            end
            for (int i = 0; i < wait_cyc; i++) begin
                step();
                n_checks++;
                if (mem_query_en !== 1'b1 || mem_head_addr !== head || fetch_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL query_hold addr=%h: query=%b head=%h ready=%b, expected 1 %h 0", addr, mem_query_en, mem_head_addr, fetch_ready, head);
                end
            end
            d = mem_word(head);
            mem_block_en = 1'b1; mem_block_data = d;
            if (clear_mode == 2) clear_in = 1'b1;
            step();
            mem_block_en = 1'b0; mem_block_data = $urandom; clear_in = 1'b0;
            n_checks++;
            if (mem_query_en !== 1'b0) begin
                n_fail++;
                $display("FAIL query_drop addr=%h: query=%b, expected 0", addr, mem_query_en);
            end
            n_checks++;
            if (fetch_ready !== (clear_mode == 0) || (clear_mode == 0 && fetch_inst !== d)) begin
                n_fail++;
                $display("FAIL fill_resp addr=%h mode=%0d: ready=%b inst=%h, expected ready=%b inst=%h", addr, clear_mode, fetch_ready, fetch_inst, clear_mode == 0, d);
            end
            m_valid[idx] = 1'b1; m_tag[idx] = m_tg(addr); m_data[idx] = d;
            step();
        end
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_end addr=%h: ready=%b, expected 0", addr, fetch_ready);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        for (int i = 0; i < M_LINES; i++) m_valid[i] = 1'b0;
        n_checks++;
        if (fetch_ready !== 1'b0 || fetch_inst !== 32'h0 || mem_query_en !== 1'b0 || mem_head_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: ready=%b inst=%h query=%b head=%h, expected all 0", fetch_ready, fetch_inst, mem_query_en, mem_head_addr);
        end
    endtask

    task automatic test_first_miss();
        do_fetch(32'h10, 0, MEM_READ_CYCLES + CTRL_CYCLES - 1);
    endtask

    task automatic test_back_to_back();
        do_fetch(32'h10, 0, 1);
        fetch_en = 1'b1; fetch_addr = 32'h10;
        step();
        n_checks++;
        if (fetch_ready !== 1'b1 || fetch_inst !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL b2b_first: ready=%b inst=%h, expected 1 00500093", fetch_ready, fetch_inst);
        end
        fetch_addr = 32'h13;
        step();
        fetch_en = 1'b0;
        n_checks++;
        if (fetch_ready !== 1'b1 || fetch_inst !== 32'h0050_0093 || mem_query_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: ready=%b inst=%h query=%b, expected 1 00500093 0", fetch_ready, fetch_inst, mem_query_en);
        end
        step();
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: ready=%b, expected 0", fetch_ready);
        end
    endtask

    task automatic test_conflict();
        do_fetch(32'h10, 0, 2);
        do_fetch(32'h50, 0, 3);
        do_fetch(32'h10, 0, 1);
        do_fetch(32'h50, 0, 2);
    endtask

    task automatic test_clear_miss();
        do_fetch(32'h20, 1, 3);
        do_fetch(32'h20, 0, 1);
        do_fetch(32'h64, 2, 2);
        do_fetch(32'h64, 0, 1);
    endtask

    task automatic test_rdy();
        logic [31:0] d;
        d = mem_word(32'h80);
        fetch_en = 1'b1; fetch_addr = 32'h80;
        step();
        fetch_en = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (mem_query_en !== 1'b1 || mem_head_addr !== 32'h80 || fetch_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rdy_miss_hold: query=%b head=%h ready=%b, expected 1 00000080 0", mem_query_en, mem_head_addr, fetch_ready);
            end
        end
        rdy_in = 1'b1;
        step();
        mem_block_en = 1'b1; mem_block_data = d;
        step();
        mem_block_en = 1'b0;
        m_valid[m_idx(32'h80)] = 1'b1; m_tag[m_idx(32'h80)] = m_tg(32'h80); m_data[m_idx(32'h80)] = d;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fetch_ready !== 1'b1 || fetch_inst !== d || mem_query_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rdy_pulse_hold: ready=%b inst=%h query=%b, expected 1 %h 0", fetch_ready, fetch_inst, mem_query_en, d);
            end
        end
        rdy_in = 1'b1;
        step();
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_pulse_once: ready=%b, expected 0", fetch_ready);
        end
        do_fetch(32'h80, 0, 1);
    endtask

    task automatic test_reset_mid_miss();
        do_fetch(32'h10, 0, 1);
        fetch_en = 1'b1; fetch_addr = 32'h1C4;
        step();
        fetch_en = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        for (int i = 0; i < M_LINES; i++) m_valid[i] = 1'b0;
        n_checks++;
        if (fetch_ready !== 1'b0 || fetch_inst !== 32'h0 || mem_query_en !== 1'b0 || mem_head_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_miss: ready=%b inst=%h query=%b head=%h, expected all 0", fetch_ready, fetch_inst, mem_query_en, mem_head_addr);
        end
        // Late controller reply after reset must be ignored.
        mem_block_en = 1'b1; mem_block_data = mem_word(32'h1C4);
        step();
        mem_block_en = 1'b0;
        n_checks++;
        if (fetch_ready !== 1'b0 || mem_query_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_block: ready=%b query=%b, expected 0 0", fetch_ready, mem_query_en);
        end
        do_fetch(32'h10, 0, 2);
        do_fetch(32'h1C4, 0, 1);
    endtask

    task automatic test_clear_idle();
        // Miss address with clear: nothing issued.
        fetch_en = 1'b1; fetch_addr = 32'h300; clear_in = 1'b1;
        step();
        fetch_en = 1'b0; clear_in = 1'b0;
        n_checks++;
        if (mem_query_en !== 1'b0 || fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle_miss: query=%b ready=%b, expected 0 0", mem_query_en, fetch_ready);
        end
        // Hit address with clear: no response.
        fetch_en = 1'b1; fetch_addr = 32'h10; clear_in = 1'b1;
        step();
        fetch_en = 1'b0; clear_in = 1'b0;
        n_checks++;
        if (mem_query_en !== 1'b0 || fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle_hit: query=%b ready=%b, expected 0 0", mem_query_en, fetch_ready);
        end
        // Clear while a response is showing, with a fetch in the same cycle.
        fetch_en = 1'b1; fetch_addr = 32'h10;
        step();
        clear_in = 1'b1;
        step();
        fetch_en = 1'b0; clear_in = 1'b0;
        n_checks++;
        if (fetch_ready !== 1'b0 || mem_query_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_stale: ready=%b query=%b, expected 0 0", fetch_ready, mem_query_en);
        end
        do_fetch(32'h300, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 28);
            r = int'($urandom_range(0, 9));
            do_fetch(a, (r == 8) ? 1 : (r == 9) ? 2 : 0, int'($urandom_range(1, 6)));
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        fetch_en = 1'b0; fetch_addr = '0;
        mem_block_en = 1'b0; mem_block_data = '0;
        test_reset();
        test_first_miss();
        test_back_to_back();
        test_conflict();
        test_clear_miss();
        test_rdy();
        test_reset_mid_miss();
        test_clear_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
